exec_pc_unit: RTL and testbench
===============================

Name: exec_pc_unit

Overview:
- Combines the execute-stage datapath of the single-cycle RV32 core:
  - a 32-bit combinational ALU;
  - branch/jump resolution (the jump controller);
  - the architectural program counter register.
- Consumes operands already selected by the decode/register-file stage.
- Feeds the write-back value to the register file and the next PC to instruction fetch.

Parameters:
XLEN, 32, datapath and PC width (only 32 supported)
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock; PC updates on rising edge
rst_n  input  1  synchronous active-low reset
alu_fn  input  5  operation code (encoding in Behaviour)
rs1_data  input  32  operand 1 (muxed: rs1, PC or zero)
rs2_data  input  32  operand 2 (muxed: rs2, immediate, etc.)
imm  input  32  sign-extended immediate; used for branch target
alu_out  output  32  ALU / link result to write-back
jump_flag  output  1  taken branch or jump this cycle
jump_target  output  32  redirect address when jump_flag=1
pc  output  32  current program counter (registered)

Behaviour:
- alu_fn encoding (decimal):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA
  - 8 SLT, 9 SLTU
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU
  - 16 JAL, 17 JALR, 18 COPY1
  - 19..31 reserved
- ALU is purely combinational; alu_out settles in the same cycle as its inputs.
  - Arithmetic is modulo 2^32; overflow is ignored.
  - Shift amount is rs2_data[4:0]; SRA replicates bit 31.
  - SLT is a signed compare, SLTU unsigned; result is 32'd1 or 32'd0.
  - COPY1: alu_out = rs1_data (used for LUI).
  - Branch codes 10..15: alu_out = 0.
  - JAL/JALR: alu_out = pc + 4, the link value.
  - Reserved codes: alu_out = 0, jump_flag = 0.
- Jump controller is combinational:
  - Branches: jump_flag = condition on rs1_data vs rs2_data (signed for BLT/BGE, unsigned for BLTU/BGEU); jump_target = pc + imm.
  - JAL: jump_flag = 1; jump_target = rs1_data + rs2_data (operands are pc and imm).
  - JALR: jump_flag = 1; jump_target = (rs1_data + rs2_data) & ~32'h1.
  - All other codes: jump_flag = 0; jump_target = pc + 4.
- Misaligned targets are not trapped; bit 1 is passed through unchanged.
- PC register, on each rising clk:
  - rst_n=0: pc <= RESET_VECTOR, regardless of jump_flag.
  - else if jump_flag: pc <= jump_target.
  - else: pc <= pc + 4.
- pc reads RESET_VECTOR from the first edge with rst_n low until the next edge with rst_n high.
- Combinational outputs remain evaluated during reset but have no architectural effect.
- Wrap-around: pc = 32'hFFFF_FFFC without jump -> 32'h0000_0000.
- Latency: redirect takes effect one edge after the branch/jump is presented. No stall or enable input; PC advances every cycle.

Decomposition:
- Package exec_pkg holds:
  - XLEN;
  - the alu_fn localparams/enum (FN_ADD .. FN_COPY1);
  - the default RESET_VECTOR.
- One natural sub-module, alu_core: the pure combinational ALU, instantiated once.
- Jump resolution and the PC register stay in exec_pc_unit.

Test Plan:
- Reset: rst_n=0 for 2 edges -> pc=0. Release with alu_fn=ADD -> pc = 4, 8, 12 on successive edges.
- ALU: SUB 5-7 -> FFFF_FFFE. SRA 8000_0000 by 4 -> F800_0000. SLT FFFF_FFFF,1 -> 1. SLTU FFFF_FFFF,1 -> 0. COPY1 1234_5000 -> 1234_5000.
- Branches at pc=0x100, imm=0x20:
  - BEQ 3,3 -> jump_flag=1, target 0x120, next pc 0x120.
  - BNE 3,3 -> jump_flag=0, next pc 0x104.
  - BLT FFFF_FFFF,0 taken; BLTU same operands not taken.
- Jumps at pc=0x40:
  - JAL rs1=0x40, rs2=0x10 -> alu_out 0x44, next pc 0x50.
  - JALR rs1=0x203, rs2=0 -> target 0x202.
- Boundaries:
  - pc=FFFF_FFFC no jump -> 0.
  - rst_n=0 with jump_flag=1 -> pc=RESET_VECTOR.
  - Reserved fn 25 -> alu_out=0, jump_flag=0.

Source files
------------

// File: rtl/exec_pkg.sv
// +--------------------------------------------------------------------+
// | exec_pkg : shared constants and alu_fn codes for the execute stage |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package exec_pkg;
  localparam int          XLEN                 = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam logic [4:0] FN_ADD   = 5'd0;
  localparam logic [4:0] FN_SUB   = 5'd1;
  localparam logic [4:0] FN_AND   = 5'd2;
  localparam logic [4:0] FN_OR    = 5'd3;
  localparam logic [4:0] FN_XOR   = 5'd4;
  localparam logic [4:0] FN_SLL   = 5'd5;
  localparam logic [4:0] FN_SRL   = 5'd6;
  localparam logic [4:0] FN_SRA   = 5'd7;
  localparam logic [4:0] FN_SLT   = 5'd8;
  localparam logic [4:0] FN_SLTU  = 5'd9;
  localparam logic [4:0] FN_BEQ   = 5'd10;
  localparam logic [4:0] FN_BNE   = 5'd11;
  localparam logic [4:0] FN_BLT   = 5'd12;
  localparam logic [4:0] FN_BGE   = 5'd13;
  localparam logic [4:0] FN_BLTU  = 5'd14;
  localparam logic [4:0] FN_BGEU  = 5'd15;
  localparam logic [4:0] FN_JAL   = 5'd16;
  localparam logic [4:0] FN_JALR  = 5'd17;
  localparam logic [4:0] FN_COPY1 = 5'd18;
endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// +--------------------------------------------------------------------+
// | alu_core : 32-bit combinational ALU; branches and reserved give 0  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_core
  import exec_pkg::*;
(
  input  logic [4:0]      i_fn,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_link,
  output logic [XLEN-1:0] o_result
);

  logic w_lt_s;
  logic w_lt_u;

  assign w_lt_s = $signed(i_a) < $signed(i_b);
  assign w_lt_u = i_a < i_b;

  always_comb begin
    o_result = '0;
    case (i_fn)
      FN_ADD:   o_result = i_a + i_b;
      FN_SUB:   o_result = i_a - i_b;
      FN_AND:   o_result = i_a & i_b;
      FN_OR:    o_result = i_a | i_b;
      FN_XOR:   o_result = i_a ^ i_b;
      FN_SLL:   o_result = i_a << i_b[4:0];
      FN_SRL:   o_result = i_a >> i_b[4:0];
      FN_SRA:   o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
      FN_SLT:   o_result = {{(XLEN-1){1'b0}}, w_lt_s};
      FN_SLTU:  o_result = {{(XLEN-1){1'b0}}, w_lt_u};
      FN_JAL,
      FN_JALR:  o_result = i_link;
      FN_COPY1: o_result = i_a;
      default:  o_result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/exec_pc_unit.sv
// +--------------------------------------------------------------------+
// | exec_pc_unit : ALU, jump resolution and architectural PC register  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module exec_pc_unit #(
  parameter int          XLEN         = exec_pkg::XLEN,
  parameter logic [31:0] RESET_VECTOR = exec_pkg::RESET_VECTOR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      alu_fn,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] alu_out,
  output logic            jump_flag,
  output logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc
);
  import exec_pkg::*;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_sum;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_eq;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_target = r_pc + imm;
  assign w_sum       = rs1_data + rs2_data;
  assign w_lt_s      = $signed(rs1_data) < $signed(rs2_data);
  assign w_lt_u      = rs1_data < rs2_data;
  assign w_eq        = rs1_data == rs2_data;

  alu_core u_alu_core (
    .i_fn     (alu_fn),
    .i_a      (rs1_data),
    .i_b      (rs2_data),
    .i_link   (w_pc_plus4),
    .o_result (alu_out)
  );

  // Branch targets are pc-relative even when not taken; non-branches fall through.
  always_comb begin
    jump_flag   = 1'b0;
    jump_target = w_pc_plus4;
    case (alu_fn)
      FN_BEQ:  begin jump_flag = w_eq;    jump_target = w_br_target; end
      FN_BNE:  begin jump_flag = !w_eq;   jump_target = w_br_target; end
      FN_BLT:  begin jump_flag = w_lt_s;  jump_target = w_br_target; end
      FN_BGE:  begin jump_flag = !w_lt_s; jump_target = w_br_target; end
      FN_BLTU: begin jump_flag = w_lt_u;  jump_target = w_br_target; end
      FN_BGEU: begin jump_flag = !w_lt_u; jump_target = w_br_target; end
      FN_JAL:  begin jump_flag = 1'b1;    jump_target = w_sum; end
      FN_JALR: begin jump_flag = 1'b1;    jump_target = {w_sum[XLEN-1:1], 1'b0}; end
      default: begin jump_flag = 1'b0;    jump_target = w_pc_plus4; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_VECTOR;
    end else if (jump_flag) begin
      r_pc <= jump_target;
    end else begin
      r_pc <= w_pc_plus4;
    end
  end

  assign pc = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_exec_pc_unit.sv
// +--------------------------------------------------------------------+
// | tb_exec_pc_unit : directed self-checking bench for exec_pc_unit    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_exec_pc_unit;
  import exec_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  alu_fn;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic        jump_flag;
  logic [31:0] jump_target;
  logic [31:0] pc;

  int errors;
  int checks;

  exec_pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_fn      (alu_fn),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .alu_out     (alu_out),
    .jump_flag   (jump_flag),
    .jump_target (jump_target),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im);
    alu_fn   = fn;
    rs1_data = a;
    rs2_data = b;
    imm      = im;
    #1;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; errors = 0; checks = 0;
    alu_fn = FN_ADD; rs1_data = '0; rs2_data = '0; imm = '0;

    tick(); tick();
    chk("reset_pc", pc, 32'h0);
    rst_n = 1'b1;
    tick(); chk("pc_4", pc, 32'd4);
    tick(); chk("pc_8", pc, 32'd8);
    tick(); chk("pc_12", pc, 32'd12);

    drive(FN_SUB, 32'd5, 32'd7, 32'h0);              chk("sub", alu_out, 32'hFFFF_FFFE);
    drive(FN_SRA, 32'h8000_0000, 32'd4, 32'h0);      chk("sra", alu_out, 32'hF800_0000);
    drive(FN_SLT, 32'hFFFF_FFFF, 32'd1, 32'h0);      chk("slt", alu_out, 32'd1);
    drive(FN_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0);     chk("sltu", alu_out, 32'd0);
    drive(FN_COPY1, 32'h1234_5000, 32'h55, 32'h0);   chk("copy1", alu_out, 32'h1234_5000);
    drive(FN_SRL, 32'h8000_0000, 32'd4, 32'h0);      chk("srl", alu_out, 32'h0800_0000);
    drive(FN_XOR, 32'hF0F0_0000, 32'hFF00_0000, 32'h0); chk("xor", alu_out, 32'h0FF0_0000);

    // Park pc at 0x100 for the branch steps.
    drive(FN_JALR, 32'h100, 32'h0, 32'h0); tick();
    chk("pc_park_100", pc, 32'h100);
    drive(FN_BEQ, 32'd3, 32'd3, 32'h20);
    chk("beq_flag", {31'b0, jump_flag}, 32'd1);
    chk("beq_target", jump_target, 32'h120);
    chk("beq_alu_out", alu_out, 32'h0);
    tick(); chk("beq_next_pc", pc, 32'h120);

    drive(FN_JALR, 32'h100, 32'h0, 32'h0); tick();
    drive(FN_BNE, 32'd3, 32'd3, 32'h20);
    chk("bne_flag", {31'b0, jump_flag}, 32'd0);
    tick(); chk("bne_next_pc", pc, 32'h104);

    drive(FN_BLT, 32'hFFFF_FFFF, 32'h0, 32'h20);  chk("blt_flag", {31'b0, jump_flag}, 32'd1);
    drive(FN_BLTU, 32'hFFFF_FFFF, 32'h0, 32'h20); chk("bltu_flag", {31'b0, jump_flag}, 32'd0);
    drive(FN_BGEU, 32'hFFFF_FFFF, 32'h0, 32'h20); chk("bgeu_flag", {31'b0, jump_flag}, 32'd1);

    drive(FN_JALR, 32'h40, 32'h0, 32'h0); tick();
    chk("pc_park_40", pc, 32'h40);
    drive(FN_JAL, 32'h40, 32'h10, 32'h0);
    chk("jal_link", alu_out, 32'h44);
    chk("jal_target", jump_target, 32'h50);
    tick(); chk("jal_next_pc", pc, 32'h50);

    drive(FN_JALR, 32'h203, 32'h0, 32'h0);
    chk("jalr_target", jump_target, 32'h202);
    chk("jalr_link", alu_out, 32'h54);
    tick(); chk("jalr_next_pc", pc, 32'h202);

    drive(FN_JALR, 32'hFFFF_FFFC, 32'h0, 32'h0); tick();
    chk("pc_park_top", pc, 32'hFFFF_FFFC);
    drive(FN_ADD, 32'h0, 32'h0, 32'h0);
    tick(); chk("pc_wrap", pc, 32'h0);

    drive(FN_JALR, 32'h80, 32'h0, 32'h0); tick();
    rst_n = 1'b0;
    drive(FN_JAL, 32'h300, 32'h0, 32'h0);
    chk("rst_jump_flag", {31'b0, jump_flag}, 32'd1);
    tick(); chk("rst_over_jump_pc", pc, 32'h0);
    rst_n = 1'b1;

    drive(5'd25, 32'd5, 32'd6, 32'h20);
    chk("rsvd_alu_out", alu_out, 32'h0);
    chk("rsvd_flag", {31'b0, jump_flag}, 32'd0);
    chk("rsvd_target", jump_target, 32'd4);
    tick(); chk("rsvd_next_pc", pc, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
